// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: turns a PC request into a single-word memory
// read over a req/ack bus, checks alignment and range up front, survives
// branch flushes mid-fetch and gives up on a memory that never answers.
module imem_fetch_ctrl #(
   parameter logic [31:0] BASE        = 32'h0000_3000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          TIMEOUT     = 16,
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        pc_req,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [1:0]  fault_code,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [31:0] DEPTH_U      = 32'(DEPTH_WORDS);
   localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);

   localparam logic [1:0] FAULT_OK       = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_RANGE    = 2'b10;
   localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_DRAIN = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t      r_state;
   logic        r_mem_req;
   logic [31:0] r_mem_addr;
   logic [31:0] r_instr;
   logic [1:0]  r_fault;
   logic [7:0]  r_cnt;

   state_t      w_state_next;
   logic        w_mem_req_next;
   logic [31:0] w_mem_addr_next;
   logic [31:0] w_instr_next;
   logic [1:0]  w_fault_next;
   logic [7:0]  w_cnt_next;

   logic        w_misaligned;
   logic [31:0] w_offset;
   logic [31:0] w_word_idx;
   logic        w_out_of_range;

   // Address qualification: the offset is only meaningful when pc >= BASE,
   // which the first term of the range check guarantees.
   assign w_misaligned   = (pc[1:0] != 2'b00);
   assign w_offset       = pc - BASE;
   assign w_word_idx     = w_offset >> 2;
   assign w_out_of_range = (pc < BASE) || (w_word_idx >= DEPTH_U);

   // State and datapath registers, all cleared or preset by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_mem_req  <= 1'b0;
         r_mem_addr <= BASE;
         r_instr    <= 32'h0000_0000;
         r_fault    <= FAULT_OK;
         r_cnt      <= 8'd0;
      end else begin
         r_state    <= w_state_next;
         r_mem_req  <= w_mem_req_next;
         r_mem_addr <= w_mem_addr_next;
         r_instr    <= w_instr_next;
         r_fault    <= w_fault_next;
         r_cnt      <= w_cnt_next;
      end
   end

   // Next-state and next-register logic; every register holds unless a
   // transition below says otherwise.
   always_comb begin
      w_state_next    = r_state;
      w_mem_req_next  = r_mem_req;
      w_mem_addr_next = r_mem_addr;
      w_instr_next    = r_instr;
      w_fault_next    = r_fault;
      w_cnt_next      = r_cnt;

      case (r_state)
         S_IDLE: begin
            if (pc_req && !flush) begin
               if (w_misaligned) begin
                  w_instr_next = NOP_INSTR;
                  w_fault_next = FAULT_MISALIGN;
                  w_state_next = S_RESP;
               end else if (w_out_of_range) begin
                  w_instr_next = NOP_INSTR;
                  w_fault_next = FAULT_RANGE;
                  w_state_next = S_RESP;
               end else begin
                  w_mem_addr_next = pc;
                  w_mem_req_next  = 1'b1;
                  w_cnt_next      = 8'd0;
                  w_state_next    = S_BUSY;
               end
            end
         end

         S_BUSY: begin
            if (mem_ack) begin
               // Data wins over a simultaneous flush only in that the bus
               // transaction is complete; the word itself is discarded.
               w_mem_req_next = 1'b0;
               if (flush) begin
                  w_state_next = S_IDLE;
               end else begin
                  w_instr_next = mem_rdata;
                  w_fault_next = FAULT_OK;
                  w_state_next = S_RESP;
               end
            end else if (flush) begin
               // The bus cannot abort a read, so keep requesting until it
               // completes; the counter keeps running across the switch.
               w_cnt_next   = r_cnt + 8'd1;
               w_state_next = S_DRAIN;
            end else if (r_cnt == TIMEOUT_LAST) begin
               w_mem_req_next = 1'b0;
               w_instr_next   = NOP_INSTR;
               w_fault_next   = FAULT_TIMEOUT;
               w_state_next   = S_RESP;
            end else begin
               w_cnt_next = r_cnt + 8'd1;
            end
         end

         S_DRAIN: begin
            // >= because a flush on the last BUSY cycle lands here one past
            // the limit.
            if (mem_ack || (r_cnt >= TIMEOUT_LAST)) begin
               w_mem_req_next = 1'b0;
               w_state_next   = S_IDLE;
            end else begin
               w_cnt_next = r_cnt + 8'd1;
            end
         end

         S_RESP: begin
            w_state_next = S_IDLE;
         end

         default: begin
            w_state_next   = S_IDLE;
            w_mem_req_next = 1'b0;
         end
      endcase
   end

   assign instr_valid = (r_state == S_RESP) && !flush;
   assign stall       = pc_req && (r_state != S_RESP);
   assign instr       = r_instr;
   assign fault_code  = r_fault;
   assign mem_req     = r_mem_req;
   assign mem_addr    = r_mem_addr;

endmodule
